// File: rtl/mprj_stream_pad_bridge.sv
// Pad-side stream bridge: buffered, bit-reversed 8-bit ingress and a registered 16-bit egress.
// Optional beat/frame counters are built when STREAM_BRIDGE_STATS_EN is defined.
module mprj_stream_pad_bridge #(
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8
) (
    input  logic        clock,
    input  logic        RSTB,
`ifdef STREAM_BRIDGE_STATS_EN
    output logic [15:0] stat_in_beats,
    output logic [15:0] stat_out_beats,
    output logic [15:0] stat_out_frames,
`endif
    input  logic        pad_in_valid,
    input  logic        pad_in_last,
    input  logic [7:0]  pad_in_data,
    output logic        pad_in_ready,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [7:0]  m_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [15:0] s_data,
    output logic        pad_out_valid,
    output logic        pad_out_last,
    output logic [15:0] pad_out_data,
    input  logic        pad_out_ready
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);

    logic [8:0]     in_mem [IN_DEPTH];
    logic [IAW-1:0] in_wr;
    logic [IAW-1:0] in_rd;
    logic [IAW:0]   in_count;
    logic           samp_valid;
    logic           samp_last;
    logic [7:0]     samp_data;
    logic [7:0]     rev_data;
    logic           accept;
    logic           pop;
    logic [IAW+1:0] occ_next;

    always_comb begin
        rev_data = '0;
        for (int i = 0; i < 8; i++) begin
            rev_data[i] = pad_in_data[7-i];
        end
    end

    assign accept   = pad_in_valid & pad_in_ready;
    assign m_valid  = (in_count != '0);
    assign pop      = m_valid & m_ready;
    assign m_data   = m_valid ? in_mem[in_rd][7:0] : 8'h00;
    assign m_last   = m_valid ? in_mem[in_rd][8] : 1'b0;
    // Occupancy includes the beat parked in the sample register, so ready never overruns the FIFO.
    assign occ_next = (IAW+2)'(in_count) + (IAW+2)'(samp_valid)
                    + (IAW+2)'(accept) - (IAW+2)'(pop);

    always_ff @(posedge clock) begin
        if (RSTB) begin
            in_wr        <= '0;
            in_rd        <= '0;
            in_count     <= '0;
            samp_valid   <= 1'b0;
            samp_last    <= 1'b0;
            samp_data    <= '0;
            pad_in_ready <= 1'b0;
        end else begin
            samp_valid <= accept;
            if (accept) begin
                samp_data <= rev_data;
                samp_last <= pad_in_last;
            end
            if (samp_valid) begin
                in_mem[in_wr] <= {samp_last, samp_data};
                in_wr         <= in_wr + 1'b1;
            end
            if (pop) begin
                in_rd <= in_rd + 1'b1;
            end
            in_count     <= in_count + (IAW+1)'(samp_valid) - (IAW+1)'(pop);
            pad_in_ready <= (occ_next < (IAW+2)'(IN_DEPTH));
        end
    end

    logic [16:0]    out_mem [OUT_DEPTH];
    logic [OAW-1:0] out_wr;
    logic [OAW-1:0] out_rd;
    logic [OAW:0]   out_count;
    logic [OAW:0]   out_count_next;
    logic           push;
    logic           load;
    logic           opop;

    assign push           = s_valid & s_ready;
    assign load           = !pad_out_valid | pad_out_ready;
    assign opop           = load & (out_count != '0);
    assign out_count_next = out_count + (OAW+1)'(push) - (OAW+1)'(opop);

    // The pad output register only reloads when empty or drained, so a stalled beat stays put.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            out_wr        <= '0;
            out_rd        <= '0;
            out_count     <= '0;
            s_ready       <= 1'b0;
            pad_out_valid <= 1'b0;
            pad_out_last  <= 1'b0;
            pad_out_data  <= '0;
        end else begin
            if (push) begin
                out_mem[out_wr] <= {s_last, s_data};
                out_wr          <= out_wr + 1'b1;
            end
            if (opop) begin
                out_rd                       <= out_rd + 1'b1;
                {pad_out_last, pad_out_data} <= out_mem[out_rd];
            end
            if (load) begin
                pad_out_valid <= (out_count != '0);
            end
            out_count <= out_count_next;
            s_ready   <= (out_count_next < (OAW+1)'(OUT_DEPTH));
        end
    end

`ifdef STREAM_BRIDGE_STATS_EN
    always_ff @(posedge clock) begin
        if (RSTB) begin
            stat_in_beats   <= '0;
            stat_out_beats  <= '0;
            stat_out_frames <= '0;
        end else begin
            if (accept) begin
                stat_in_beats <= stat_in_beats + 16'd1;
            end
            if (pad_out_valid & pad_out_ready) begin
                stat_out_beats <= stat_out_beats + 16'd1;
                if (pad_out_last) begin
                    stat_out_frames <= stat_out_frames + 16'd1;
                end
            end
        end
    end
`endif

endmodule
